// File: rtl/chain_sink_checker.sv
// chain_sink_checker
// Receiving end of an N-stage registered increment chain. On a start pulse it
// captures seed, waits the chain latency, then compares the chain output
// against seed+CNT for up to TIMEOUT cycles and reports the outcome.
//
// Ports:
//   clk      in   clock, all state on posedge
//   rst      in   asynchronous active-high reset
//   start    in   one-cycle pulse, seed has just been driven into stage 0
//   seed     in   [W-1:0] word applied to stage 0, sampled with start
//   obs      in   [W-1:0] chain output (last stage)
//   busy     out  high while waiting or comparing
//   done     out  high once the run has finished
//   pass     out  valid with done; 1 = matching word seen
//   err_cnt  out  [7:0] mismatching compare cycles this run, saturating
//   got      out  [W-1:0] last obs value sampled while comparing
//
// Optional build macro CHAIN_SINK_CHECKER_TRACE_EN: prints one line per
// compare cycle and a FAIL line when a run ends without a match. Register
// behaviour is identical with or without it.

module chain_sink_checker #(
   parameter int CNT     = 5,
   parameter int W       = 32,
   parameter int LAT     = 5,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] seed,
   input  logic [W-1:0] obs,
   output logic         busy,
   output logic         done,
   output logic         pass,
   output logic [7:0]   err_cnt,
   output logic [W-1:0] got
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_CHECK = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int DW = (LAT > 1) ? $clog2(LAT + 1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [W-1:0]  CNT_W     = W'(CNT);
   localparam logic [DW-1:0] DLY_INIT  = (LAT > 1) ? DW'(LAT - 1) : DW'(0);
   localparam logic [DW-1:0] DLY_ONE   = DW'(1);
   localparam logic [TW-1:0] TMO_INIT  = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : TW'(0);
   localparam logic [TW-1:0] TMO_ONE   = TW'(1);
   localparam logic [TW-1:0] TMO_ZERO  = TW'(0);

   // Saturating 8-bit increment for the mismatch counter
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      if (v == 8'hFF) begin
         return v;
      end else begin
         return v + 8'd1;
      end
   endfunction

   logic [1:0]    r_state;
   logic [W-1:0]  r_exp;
   logic [DW-1:0] r_dly;
   logic [TW-1:0] r_tmo;
   logic [7:0]    r_err;
   logic          r_pass;
   logic [W-1:0]  r_got;
   logic          r_busy;
   logic          r_done;

   logic [1:0]    w_state_nxt;
   logic [W-1:0]  w_exp_nxt;
   logic [DW-1:0] w_dly_nxt;
   logic [TW-1:0] w_tmo_nxt;
   logic [7:0]    w_err_nxt;
   logic          w_pass_nxt;
   logic [W-1:0]  w_got_nxt;

   // Next-state and datapath decisions for one run
   always_comb begin
      w_state_nxt = r_state;
      w_exp_nxt   = r_exp;
      w_dly_nxt   = r_dly;
      w_tmo_nxt   = r_tmo;
      w_err_nxt   = r_err;
      w_pass_nxt  = r_pass;
      w_got_nxt   = r_got;
      case (r_state)
         S_IDLE, S_DONE: begin
            // A start in DONE is a back-to-back run; got is kept until the
            // new run samples obs.
            if (start) begin
               w_exp_nxt  = seed + CNT_W;
               w_dly_nxt  = DLY_INIT;
               w_err_nxt  = 8'd0;
               w_pass_nxt = 1'b0;
               if (LAT <= 1) begin
                  w_state_nxt = S_CHECK;
                  w_tmo_nxt   = TMO_INIT;
               end else begin
                  w_state_nxt = S_WAIT;
               end
            end else begin
               w_state_nxt = r_state;
            end
         end
         S_WAIT: begin
            // dly holds the WAIT cycles still to spend including this one,
            // so the first compare lands in cycle LAT after start.
            if (r_dly <= DLY_ONE) begin
               w_state_nxt = S_CHECK;
               w_dly_nxt   = DW'(0);
               w_tmo_nxt   = TMO_INIT;
            end else begin
               w_dly_nxt = r_dly - DLY_ONE;
            end
         end
         S_CHECK: begin
            w_got_nxt = obs;
            if (obs == r_exp) begin
               w_pass_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_err_nxt = sat_inc(r_err);
               if (r_tmo == TMO_ZERO) begin
                  w_pass_nxt  = 1'b0;
                  w_state_nxt = S_DONE;
               end else begin
                  w_tmo_nxt = r_tmo - TMO_ONE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, captured run data and registered status flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_exp   <= '0;
         r_dly   <= '0;
         r_tmo   <= '0;
         r_err   <= 8'd0;
         r_pass  <= 1'b0;
         r_got   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_exp   <= w_exp_nxt;
         r_dly   <= w_dly_nxt;
         r_tmo   <= w_tmo_nxt;
         r_err   <= w_err_nxt;
         r_pass  <= w_pass_nxt;
         r_got   <= w_got_nxt;
         r_busy  <= (w_state_nxt == S_WAIT) || (w_state_nxt == S_CHECK);
         r_done  <= (w_state_nxt == S_DONE);
      end
   end

`ifdef CHAIN_SINK_CHECKER_TRACE_EN
   // Per-compare trace and failure notice
   always @(posedge clk) begin
      if (!rst && (r_state == S_CHECK)) begin
         $display("%m chk got=%x exp=%x err=%0d", obs, r_exp, w_err_nxt);
         if ((w_state_nxt == S_DONE) && !w_pass_nxt) begin
            $display("%m FAIL");
`ifdef TEST_VERBOSE
            $stop;
`endif
         end
      end
   end
`endif

   assign busy    = r_busy;
   assign done    = r_done;
   assign pass    = r_pass;
   assign err_cnt = r_err;
   assign got     = r_got;

endmodule

// File: tb/tb_chain_sink_checker.sv
module tb_chain_sink_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] seed = 32'd0;
   logic [31:0] obs;
   logic [1:0]  obs_sel = 2'd0;

   logic        busy, done, pass;
   logic [7:0]  err_cnt;
   logic [31:0] got;
   logic        t4_busy, t4_done, t4_pass;
   logic [7:0]  t4_err_cnt;
   logic [31:0] t4_got;

   int n_asrt = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   // Reference chain: five incrementing stages then two plain delay stages
   logic [31:0] st [0:6];
   always_ff @(posedge clk) begin
      st[0] <= seed + 32'd1;
      for (int i = 1; i < 5; i++) st[i] <= st[i-1] + 32'd1;
      st[5] <= st[4];
      st[6] <= st[5];
   end

   always_comb begin
      case (obs_sel)
         2'd0:    obs = st[4];
         2'd1:    obs = st[6];
         default: obs = 32'd0;
      endcase
   end

   chain_sink_checker u_dut (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .obs(obs),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .got(got)
   );

   chain_sink_checker #(.TIMEOUT(4)) u_dut_t4 (
      .clk(clk), .rst(rst), .start(start), .seed(seed), .obs(obs),
      .busy(t4_busy), .done(t4_done), .pass(t4_pass), .err_cnt(t4_err_cnt), .got(t4_got)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_asrt++;
      assert (observed === expected) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      step(10);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_err", {24'd0, err_cnt}, 32'd0);
      check("rst_got", got, 32'd0);
      rst = 1'b0;
      step(2);

      // Matching run
      start = 1'b1; seed = 32'h1234;
      step(1);
      start = 1'b0; seed = 32'd0;
      for (int i = 1; i <= 5; i++) begin
         check("m_busy", {31'd0, busy}, 32'd1);
         check("m_done_low", {31'd0, done}, 32'd0);
         step(1);
      end
      check("m_done", {31'd0, done}, 32'd1);
      check("m_busy_end", {31'd0, busy}, 32'd0);
      check("m_pass", {31'd0, pass}, 32'd1);
      check("m_got", got, 32'h1239);
      check("m_err", {24'd0, err_cnt}, 32'd0);

      // Back-to-back start while in DONE
      start = 1'b1; seed = 32'h10;
      step(1);
      start = 1'b0; seed = 32'd0;
      check("b2b_done_drop", {31'd0, done}, 32'd0);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      check("b2b_pass_clr", {31'd0, pass}, 32'd0);
      check("b2b_got_held", got, 32'h1239);
      step(5);
      check("b2b_done", {31'd0, done}, 32'd1);
      check("b2b_pass", {31'd0, pass}, 32'd1);
      check("b2b_got", got, 32'h15);

      // Late match through two extra delay stages
      obs_sel = 2'd1;
      step(10);
      start = 1'b1; seed = 32'h1234;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(6);
      check("late_done_low", {31'd0, done}, 32'd0);
      check("late_err_mid", {24'd0, err_cnt}, 32'd2);
      step(1);
      check("late_done", {31'd0, done}, 32'd1);
      check("late_pass", {31'd0, pass}, 32'd1);
      check("late_err", {24'd0, err_cnt}, 32'd2);
      check("late_got", got, 32'h1239);

      // Timeout with obs tied to zero
      obs_sel = 2'd2;
      step(3);
      start = 1'b1; seed = 32'h1234;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(7);
      check("t4_done_low", {31'd0, t4_done}, 32'd0);
      check("t4_err_mid", {24'd0, t4_err_cnt}, 32'd3);
      step(1);
      check("t4_done", {31'd0, t4_done}, 32'd1);
      check("t4_pass", {31'd0, t4_pass}, 32'd0);
      check("t4_err", {24'd0, t4_err_cnt}, 32'd4);
      check("t4_got", t4_got, 32'd0);
      check("t16_busy_mid", {31'd0, busy}, 32'd1);
      check("t16_err_mid", {24'd0, err_cnt}, 32'd4);
      step(11);
      check("t16_done_low", {31'd0, done}, 32'd0);
      step(1);
      check("t16_done", {31'd0, done}, 32'd1);
      check("t16_pass", {31'd0, pass}, 32'd0);
      check("t16_err", {24'd0, err_cnt}, 32'd16);
      check("t16_got", got, 32'd0);

      // Wrap-around of seed + CNT
      obs_sel = 2'd0;
      step(8);
      start = 1'b1; seed = 32'hFFFF_FFFE;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(5);
      check("wrap_done", {31'd0, done}, 32'd1);
      check("wrap_pass", {31'd0, pass}, 32'd1);
      check("wrap_got", got, 32'h3);
      check("wrap_err", {24'd0, err_cnt}, 32'd0);

      // Start while busy is ignored
      step(8);
      start = 1'b1; seed = 32'h1234;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(1);
      start = 1'b1; seed = 32'h9999;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(2);
      check("busy_st_done_low", {31'd0, done}, 32'd0);
      step(1);
      check("busy_st_done", {31'd0, done}, 32'd1);
      check("busy_st_pass", {31'd0, pass}, 32'd1);
      check("busy_st_got", got, 32'h1239);
      check("busy_st_err", {24'd0, err_cnt}, 32'd0);

      // Asynchronous reset in the middle of WAIT
      step(8);
      start = 1'b1; seed = 32'h55;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(1);
      check("ar_pre_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("ar_busy", {31'd0, busy}, 32'd0);
      check("ar_done", {31'd0, done}, 32'd0);
      check("ar_pass", {31'd0, pass}, 32'd0);
      check("ar_err", {24'd0, err_cnt}, 32'd0);
      check("ar_got", got, 32'd0);
      step(3);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("ar_no_done", {31'd0, done}, 32'd0);
         step(1);
      end

      // First start after reset is honoured
      start = 1'b1; seed = 32'h20;
      step(1);
      start = 1'b0; seed = 32'd0;
      step(5);
      check("ar_run_done", {31'd0, done}, 32'd1);
      check("ar_run_pass", {31'd0, pass}, 32'd1);
      check("ar_run_got", got, 32'h25);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
